fifo_uart_tx: RTL and testbench

Read-side consumer for the team's 8-bit async FIFO. It drains bytes from the FIFO read port and serializes each one as a UART 8N1 frame. It runs in the FIFO's read clock domain and drives the FIFO's r_en. It uses the FIFO's registered dout, which is valid one cycle after the accepted read edge.

---
 rtl/fifo_uart_pkg.sv | 17 +
 rtl/fifo_uart_baud_gen.sv | 35 +++
 rtl/fifo_uart_tx.sv | 112 +++++++++++
 tb/tb_fifo_uart_tx.sv | 368 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_uart_pkg.sv
// Shared constants for the FIFO-draining UART transmitter: frame width,
// line idle level and FSM state encodings.
package fifo_uart_pkg;

    localparam int DATA_BITS = 8;
    localparam logic TX_IDLE = 1'b1;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE  = 3'd0;
    localparam state_t ST_POP   = 3'd1;
    localparam state_t ST_LOAD  = 3'd2;
    localparam state_t ST_START = 3'd3;
    localparam state_t ST_DATA  = 3'd4;
    localparam state_t ST_STOP  = 3'd5;

endpackage

// File: rtl/fifo_uart_baud_gen.sv
// Bit-period timer: counts 0..CLK_DIV-1 and flags the last cycle of each bit.
module fifo_uart_baud_gen #(
    parameter int CLK_DIV = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic tick
);

    localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign tick = (cnt_q == CNT_MAX);

    // Free-running between clears so every bit period is exactly CLK_DIV cycles.
    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (clr || tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/fifo_uart_tx.sv
// Drains bytes from the async FIFO read port and sends each as a UART 8N1 frame.
module fifo_uart_tx #(
    parameter int CLK_DIV   = 16,
    parameter int DATA_BITS = fifo_uart_pkg::DATA_BITS
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic                 empty,
    input  logic [DATA_BITS-1:0] fifo_dout,
    output logic                 r_en,
    output logic                 tx,
    output logic                 busy,
    output logic                 done,
    output logic [2:0]           dbg_state
);

    import fifo_uart_pkg::*;

    localparam int BIT_W = $clog2(DATA_BITS);

    state_t               state_q;
    state_t               state_d;
    logic [DATA_BITS-1:0] shift_q;
    logic [DATA_BITS-1:0] shift_d;
    logic [BIT_W-1:0]     bit_cnt_q;
    logic [BIT_W-1:0]     bit_cnt_d;
    logic                 baud_clr;
    logic                 baud_tick;
    logic                 start_ok;
    logic                 last_bit;

    // Read handshake: r_en is a one-cycle strobe issued only after !empty was
    // sampled; this block is the sole reader, so the FIFO always accepts it and
    // fifo_dout is valid on the following cycle (LOAD).
    assign start_ok = en && !empty;
    assign last_bit = (bit_cnt_q == BIT_W'(DATA_BITS - 1));
    assign baud_clr = (state_q == ST_LOAD);

    fifo_uart_baud_gen #(
        .CLK_DIV(CLK_DIV)
    ) u_baud (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (baud_clr),
        .tick (baud_tick)
    );

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (start_ok) state_d = ST_POP;
            end
            ST_POP: begin
                state_d = ST_LOAD;
            end
            ST_LOAD: begin
                shift_d   = fifo_dout;
                bit_cnt_d = '0;
                state_d   = ST_START;
            end
            ST_START: begin
                if (baud_tick) state_d = ST_DATA;
            end
            ST_DATA: begin
                if (baud_tick) begin
                    shift_d   = shift_q >> 1;
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (last_bit) state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                // Chaining straight to POP keeps busy high across queued bytes.
                if (baud_tick) state_d = start_ok ? ST_POP : ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            shift_q   <= '0;
            bit_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
        end
    end

    // Decoded from state so reset forces the line high without waiting for a clock.
    always_comb begin
        tx = TX_IDLE;
        case (state_q)
            ST_START: tx = ~TX_IDLE;
            ST_DATA:  tx = shift_q[0];
            default:  tx = TX_IDLE;
        endcase
    end

    assign r_en      = (state_q == ST_POP);
    assign busy      = (state_q != ST_IDLE);
    assign done      = (state_q == ST_STOP) && baud_tick;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench for fifo_uart_tx: one instance at CLK_DIV=4, one at CLK_DIV=2,
// each fed by a small behavioural FIFO read port.
module tb_fifo_uart_tx;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    // Instance A: CLK_DIV = 4
    logic       en_a = 1'b0;
    logic       empty_a;
    logic [7:0] dout_a = 8'h00;
    logic       r_en_a, tx_a, busy_a, done_a;
    logic [2:0] st_a;
    logic [7:0] mem_a [0:15];
    int         push_a = 0;
    int         pop_a  = 0;

    // Instance B: CLK_DIV = 2
    logic       en_b = 1'b0;
    logic       empty_b;
    logic [7:0] dout_b = 8'h00;
    logic       r_en_b, tx_b, busy_b, done_b;
    logic [2:0] st_b;
    logic [7:0] mem_b [0:15];
    int         push_b = 0;
    int         pop_b  = 0;

    int checks = 0;
    int errors = 0;

    logic [7:0] exp_q[$];

    logic tx_l   [0:255];
    logic ren_l  [0:255];
    logic busy_l [0:255];
    logic done_l [0:255];
    logic txb_l  [0:255];
    logic renb_l [0:255];
    logic busyb_l[0:255];
    logic doneb_l[0:255];

    fifo_uart_tx #(.CLK_DIV(4)) dut_a (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en_a),
        .empty    (empty_a),
        .fifo_dout(dout_a),
        .r_en     (r_en_a),
        .tx       (tx_a),
        .busy     (busy_a),
        .done     (done_a),
        .dbg_state(st_a)
    );

    fifo_uart_tx #(.CLK_DIV(2)) dut_b (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en_b),
        .empty    (empty_b),
        .fifo_dout(dout_b),
        .r_en     (r_en_b),
        .tx       (tx_b),
        .busy     (busy_b),
        .done     (done_b),
        .dbg_state(st_b)
    );

    // Behavioural FIFO read ports: registered dout, flushed by the shared reset.
    assign empty_a = (push_a == pop_a);
    assign empty_b = (push_b == pop_b);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pop_a <= push_a;
        end else if (r_en_a && !empty_a) begin
            dout_a <= mem_a[pop_a[3:0]];
            pop_a  <= pop_a + 1;
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pop_b <= push_b;
        end else if (r_en_b && !empty_b) begin
            dout_b <= mem_b[pop_b[3:0]];
            pop_b  <= pop_b + 1;
        end
    end

    task automatic push_byte_a(input logic [7:0] b);
        mem_a[push_a[3:0]] = b;
        push_a = push_a + 1;
    endtask

    task automatic push_byte_b(input logic [7:0] b);
        mem_b[push_b[3:0]] = b;
        push_b = push_b + 1;
    endtask

    // Sample both instances each negedge; optionally drop en_a after sample drop_at.
    task automatic capture(input int n, input int drop_at);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            tx_l[i]    = tx_a;
            ren_l[i]   = r_en_a;
            busy_l[i]  = busy_a;
            done_l[i]  = done_a;
            txb_l[i]   = tx_b;
            renb_l[i]  = r_en_b;
            busyb_l[i] = busy_b;
            doneb_l[i] = done_b;
            if (i == drop_at) en_a = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (tx_a !== 1'b1 || r_en_a !== 1'b0 || busy_a !== 1'b0 || done_a !== 1'b0) begin
            errors++;
            $display("FAIL reset_a: tx/r_en/busy/done=%b%b%b%b, required 1000", tx_a, r_en_a, busy_a, done_a);
        end
        checks++;
        if (tx_b !== 1'b1 || r_en_b !== 1'b0 || busy_b !== 1'b0 || done_b !== 1'b0) begin
            errors++;
            $display("FAIL reset_b: tx/r_en/busy/done=%b%b%b%b, required 1000", tx_b, r_en_b, busy_b, done_b);
        end
        checks++;
        if (st_a !== 3'd0) begin
            errors++;
            $display("FAIL reset_state: state=%0d, required 0 (IDLE)", st_a);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_empty();
        int n_ren, n_low, n_busy;
        n_ren = 0; n_low = 0; n_busy = 0;
        en_a = 1'b1;
        capture(200, -1);
        for (int i = 0; i < 200; i++) begin
            if (ren_l[i] !== 1'b0) n_ren++;
            if (tx_l[i] !== 1'b1) n_low++;
            if (busy_l[i] !== 1'b0) n_busy++;
        end
        checks++;
        if (n_ren != 0) begin errors++; $display("FAIL empty_r_en: %0d cycles with r_en, required 0", n_ren); end
        checks++;
        if (n_low != 0) begin errors++; $display("FAIL empty_tx: %0d cycles with tx!=1, required 0", n_low); end
        checks++;
        if (n_busy != 0) begin errors++; $display("FAIL empty_busy: %0d busy cycles, required 0", n_busy); end
    endtask

    task automatic test_single_byte();
        logic [7:0] byte_v;
        logic       lvl;
        int         bad, n_ren, n_done;
        byte_v = 8'hA5;
        @(negedge clk);
        push_byte_a(byte_v);
        capture(60, -1);
        n_ren = 0; n_done = 0;
        for (int i = 0; i < 60; i++) begin
            if (ren_l[i] === 1'b1) n_ren++;
            if (done_l[i] === 1'b1) n_done++;
        end
        checks++;
        if (n_ren != 1 || ren_l[0] !== 1'b1) begin
            errors++;
            $display("FAIL single_r_en: %0d pulses (r_en[0]=%b), required 1 at cycle 0", n_ren, ren_l[0]);
        end
        for (int k = 0; k < 10; k++) begin
            lvl = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : byte_v[k-1];
            bad = 0;
            for (int c = 0; c < 4; c++) if (tx_l[2 + 4*k + c] !== lvl) bad++;
            checks++;
            if (bad != 0) begin
                errors++;
                $display("FAIL single_tx_bit%0d: %0d of 4 cycles wrong (first=%b), required %b", k, bad, tx_l[2 + 4*k], lvl);
            end
        end
        checks++;
        if (n_done != 1 || done_l[41] !== 1'b1) begin
            errors++;
            $display("FAIL single_done: %0d pulses (done@41=%b), required 1 at frame cycle 40", n_done, done_l[41]);
        end
        checks++;
        if (busy_l[41] !== 1'b1 || busy_l[42] !== 1'b0) begin
            errors++;
            $display("FAIL single_busy_fall: busy@41=%b busy@42=%b, required 1 then 0", busy_l[41], busy_l[42]);
        end
    endtask

    task automatic test_back_to_back();
        int         ren_pos[$];
        int         done_pos[$];
        int         bad, base;
        logic [7:0] got, exp;
        @(negedge clk);
        push_byte_a(8'h00); exp_q.push_back(8'h00);
        push_byte_a(8'hFF); exp_q.push_back(8'hFF);
        push_byte_a(8'h3C); exp_q.push_back(8'h3C);
        capture(140, -1);
        for (int i = 0; i < 140; i++) begin
            if (ren_l[i] === 1'b1) ren_pos.push_back(i);
            if (done_l[i] === 1'b1) done_pos.push_back(i);
        end
        checks++;
        if (ren_pos.size() != 3 || ren_pos[0] != 0 || ren_pos[1] != 42 || ren_pos[2] != 84) begin
            errors++;
            $display("FAIL b2b_r_en: %0d pulses, required 3 at cycles 0,42,84", ren_pos.size());
        end
        checks++;
        if (done_pos.size() != 3 || done_pos[0] != 41 || done_pos[1] != 83 || done_pos[2] != 125) begin
            errors++;
            $display("FAIL b2b_done: %0d pulses, required 3 at cycles 41,83,125", done_pos.size());
        end
        bad = 0;
        for (int i = 0; i < 126; i++) if (busy_l[i] !== 1'b1) bad++;
        checks++;
        if (bad != 0 || busy_l[126] !== 1'b0) begin
            errors++;
            $display("FAIL b2b_busy: %0d low cycles in 0..125, busy@126=%b, required 0 and 0", bad, busy_l[126]);
        end
        for (int f = 0; f < 3; f++) begin
            base = 2 + 42*f;
            checks++;
            if (tx_l[base - 1] !== 1'b1 || tx_l[base] !== 1'b0 || tx_l[base + 37] !== 1'b1) begin
                errors++;
                $display("FAIL b2b_framing%0d: tx pre/start/stop=%b%b%b, required 101", f, tx_l[base - 1], tx_l[base], tx_l[base + 37]);
            end
            for (int j = 0; j < 8; j++) got[j] = tx_l[base + 4*(j + 1) + 1];
            exp = exp_q.pop_front();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL b2b_byte%0d: decoded %h, required %h", f, got, exp);
            end
        end
    endtask

    task automatic test_en_drop();
        logic [7:0] got;
        int         n_ren, n_done;
        @(negedge clk);
        push_byte_a(8'h96);
        push_byte_a(8'h4B);
        // Sample 19 is the second cycle of data bit 3 (cycles 18..21).
        capture(60, 19);
        n_ren = 0; n_done = 0;
        for (int i = 0; i < 60; i++) begin
            if (ren_l[i] === 1'b1) n_ren++;
            if (done_l[i] === 1'b1) n_done++;
        end
        for (int j = 0; j < 8; j++) got[j] = tx_l[2 + 4*(j + 1) + 1];
        checks++;
        if (got !== 8'h96 || tx_l[2] !== 1'b0 || tx_l[39] !== 1'b1) begin
            errors++;
            $display("FAIL en_drop_frame: decoded %h start=%b stop=%b, required 96 0 1", got, tx_l[2], tx_l[39]);
        end
        checks++;
        if (n_ren != 1 || n_done != 1 || done_l[41] !== 1'b1) begin
            errors++;
            $display("FAIL en_drop_pulses: r_en=%0d done=%0d, required 1 and 1", n_ren, n_done);
        end
        checks++;
        if (empty_a !== 1'b0 || busy_l[59] !== 1'b0) begin
            errors++;
            $display("FAIL en_drop_hold: empty=%b busy=%b, required 0 and 0", empty_a, busy_l[59]);
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] got;
        int         n_ren, n_done;
        @(negedge clk);
        en_a = 1'b1;
        // Leftover 0x4B goes out; sample 27 falls in data bit 5, which is 0.
        capture(28, -1);
        checks++;
        if (tx_l[27] !== 1'b0 || busy_l[27] !== 1'b1) begin
            errors++;
            $display("FAIL mid_frame_pre: tx=%b busy=%b, required 0 and 1", tx_l[27], busy_l[27]);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (tx_a !== 1'b1 || busy_a !== 1'b0 || r_en_a !== 1'b0) begin
            errors++;
            $display("FAIL mid_frame_reset: tx=%b busy=%b r_en=%b, required 1 0 0", tx_a, busy_a, r_en_a);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        push_byte_a(8'h81);
        capture(60, -1);
        n_ren = 0; n_done = 0;
        for (int i = 0; i < 60; i++) begin
            if (ren_l[i] === 1'b1) n_ren++;
            if (done_l[i] === 1'b1) n_done++;
        end
        for (int j = 0; j < 8; j++) got[j] = tx_l[2 + 4*(j + 1) + 1];
        checks++;
        if (got !== 8'h81 || tx_l[1] !== 1'b1 || tx_l[2] !== 1'b0 || tx_l[39] !== 1'b1) begin
            errors++;
            $display("FAIL after_reset_frame: decoded %h start=%b stop=%b, required 81 0 1", got, tx_l[2], tx_l[39]);
        end
        checks++;
        if (n_ren != 1 || ren_l[0] !== 1'b1 || n_done != 1 || done_l[41] !== 1'b1 || busy_l[42] !== 1'b0) begin
            errors++;
            $display("FAIL after_reset_ctrl: r_en=%0d done=%0d busy@42=%b, required 1 1 0", n_ren, n_done, busy_l[42]);
        end
        en_a = 1'b0;
    endtask

    task automatic test_min_divider();
        logic [7:0] byte_v;
        logic       lvl;
        int         bad, n_ren, n_done;
        byte_v = 8'h55;
        @(negedge clk);
        en_b = 1'b1;
        push_byte_b(byte_v);
        capture(40, -1);
        n_ren = 0; n_done = 0;
        for (int i = 0; i < 40; i++) begin
            if (renb_l[i] === 1'b1) n_ren++;
            if (doneb_l[i] === 1'b1) n_done++;
        end
        for (int k = 0; k < 10; k++) begin
            lvl = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : byte_v[k-1];
            bad = 0;
            for (int c = 0; c < 2; c++) if (txb_l[2 + 2*k + c] !== lvl) bad++;
            checks++;
            if (bad != 0) begin
                errors++;
                $display("FAIL div2_tx_bit%0d: %0d of 2 cycles wrong (first=%b), required %b", k, bad, txb_l[2 + 2*k], lvl);
            end
        end
        checks++;
        if (n_done != 1 || doneb_l[21] !== 1'b1) begin
            errors++;
            $display("FAIL div2_done: %0d pulses (done@21=%b), required 1 at frame cycle 20", n_done, doneb_l[21]);
        end
        checks++;
        if (n_ren != 1 || renb_l[0] !== 1'b1 || busyb_l[21] !== 1'b1 || busyb_l[22] !== 1'b0) begin
            errors++;
            $display("FAIL div2_ctrl: r_en=%0d busy@21=%b busy@22=%b, required 1 1 0", n_ren, busyb_l[21], busyb_l[22]);
        end
    endtask

    initial begin
        test_reset();
        test_empty();
        test_single_byte();
        test_back_to_back();
        test_en_drop();
        test_reset_mid_frame();
        test_min_divider();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
